// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: sequencer states, port ids
// and the address bit that separates ROM (0) from RAM (1).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam int unsigned SEL_BIT = 15;

endpackage

// File: rtl/mem_arbiter_rr_grant2.sv
// Combinational two-request round-robin chooser; the pointer register
// lives in the arbiter.
module rr_grant2
    import mem_arbiter_pkg::*;
(
    input  logic  req_a,
    input  logic  req_b,
    input  port_t prio,
    output logic  gnt_valid,
    output port_t gnt_id
);

    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_id    = PORT_A;
        if (req_a && req_b) begin
            gnt_id = prio;
        end else if (req_b) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared ROM/RAM block with a
// fixed IDLE -> ACCESS -> RESP sequence; writes into ROM are rejected.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [7:0]  b_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);

    state_t      state;
    port_t       prio;
    port_t       gid;
    logic [15:0] laddr;
    logic        lwe;
    logic [7:0]  lwdata;
    logic        gnt_valid;
    port_t       gnt_id;
    logic        rom_wr;

    rr_grant2 u_grant (
        .req_a     (a_req),
        .req_b     (b_req),
        .prio      (prio),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign rom_wr = lwe & ~laddr[SEL_BIT];

    // Memory pins are decoded from state so that reset kills mem_we at once.
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (state == ACCESS) begin
            mem_addr = laddr;
            mem_din  = lwdata;
            mem_we   = lwe & laddr[SEL_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= PORT_A;
            gid     <= PORT_A;
            laddr   <= '0;
            lwe     <= 1'b0;
            lwdata  <= '0;
            a_ack   <= 1'b0;
            a_err   <= 1'b0;
            a_rdata <= '0;
            b_ack   <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gid   <= gnt_id;
                        prio  <= (gnt_id == PORT_A) ? PORT_B : PORT_A;
                        state <= ACCESS;
                        if (gnt_id == PORT_B) begin
                            laddr  <= b_addr;
                            lwe    <= b_we;
                            lwdata <= b_wdata;
                        end else begin
                            laddr  <= a_addr;
                            lwe    <= a_we;
                            lwdata <= a_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (gid == PORT_B) begin
                        b_ack   <= 1'b1;
                        b_err   <= rom_wr;
                        b_rdata <= rom_wr ? 8'h00 : mem_dout;
                    end else begin
                        a_ack   <= 1'b1;
                        a_err   <= rom_wr;
                        a_rdata <= rom_wr ? 8'h00 : mem_dout;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    a_ack <= 1'b0;
                    a_err <= 1'b0;
                    b_ack <= 1'b0;
                    b_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// random two-port traffic checked against a transaction-level memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [7:0]  a_rdata, b_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    bit         mem_init = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_err    (a_err),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_err    (b_err),
        .b_rdata  (b_rdata),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    function automatic logic [7:0] init_val(input int unsigned i);
        logic [31:0] v;
        v = i;
        return v[7:0] ^ v[15:8] ^ 8'hA5;
    endfunction

    // Memory block: asynchronous read, write on the rising edge.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input bit req, input bit we,
                         input logic [15:0] addr, input logic [7:0] wd);
        if (p) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ports"}, {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata}, 64'h0);
        check({tag, "_mem"}, {mem_we, mem_addr, mem_din}, 64'h0);
    endtask

    // One isolated access from an idle arbiter; starts and ends just after a falling edge.
    task automatic run_access(input bit p, input bit we, input logic [15:0] addr,
                              input logic [7:0] wd);
        bit         exp_err;
        logic [7:0] exp_rd;
        exp_err = we && !addr[15];
        exp_rd  = exp_err ? 8'h00 : ref_mem[addr];
        drive(p, 1'b1, we, addr, wd);
        @(negedge clk);
        check("acc_addr", mem_addr, addr);
        check("acc_we", mem_we, we && addr[15]);
        if (we) check("acc_din", mem_din, wd);
        check("acc_noack", {a_ack, b_ack}, 2'b00);
        @(negedge clk);
        check("ack", p ? {b_ack, a_ack} : {a_ack, b_ack}, 2'b10);
        check("err", p ? b_err : a_err, exp_err);
        if (!we || exp_err) check("rdata", p ? b_rdata : a_rdata, exp_rd);
        drive(p, 1'b0, 1'b0, 16'h0, 8'h0);
        if (we && addr[15]) ref_mem[addr] = wd;
        @(negedge clk);
        check("post_idle", {a_ack, b_ack, mem_we, mem_addr}, 64'h0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit          pend [2];
        int unsigned wt   [2];
        logic        rwe  [2];
        logic [15:0] rad  [2];
        logic [7:0]  rwd  [2];
        int unsigned idx;
        bit          exp_port [4];
        bit          ack_v, err_v, perr;
        logic [7:0]  rd_v, erd;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // RAM write then read-back, and the pre-written single read.
        run_access(1'b1, 1'b1, 16'hC000, 8'h3C);
        run_access(1'b0, 1'b0, 16'hC000, 8'h00);
        check("ram_readback", a_rdata, 8'h3C);
        run_access(1'b1, 1'b1, 16'h8010, 8'h5A);
        run_access(1'b0, 1'b0, 16'h8010, 8'h00);
        check("single_read", a_rdata, 8'h5A);

        // Reset mid-run clears everything, then stays quiet.
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_we", mem_we, 1'b0);
        end

        // ROM write rejected, ROM contents unchanged.
        run_access(1'b0, 1'b1, 16'h0100, 8'hEE);
        run_access(1'b0, 1'b0, 16'h0100, 8'h00);
        check("rom_unchanged", a_rdata, init_val(32'h0100));

        // Contention from a fresh reset: A first, then strict alternation every 3 cycles.
        pulse_reset();
        exp_port[0] = 1'b0; exp_port[1] = 1'b1; exp_port[2] = 1'b0; exp_port[3] = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 16'h8010, 8'h0);
        drive(1'b1, 1'b1, 1'b0, 16'hC000, 8'h0);
        idx = 0;
        for (int unsigned k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                check("cont_both", {a_ack, b_ack} == 2'b11, 1'b0);
                if (idx < 4) begin
                    check("cont_order", b_ack, exp_port[idx]);
                    check("cont_spacing", k, 2 + 3 * idx);
                    check("cont_rdata", b_ack ? b_rdata : a_rdata, b_ack ? 8'h3C : 8'h5A);
                end
                idx++;
            end
        end
        check("cont_count", idx, 4);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        repeat (3) @(negedge clk);

        // Reset during the ACCESS cycle of a RAM write aborts it.
        run_access(1'b0, 1'b1, 16'h8001, 8'h11);
        drive(1'b0, 1'b1, 1'b1, 16'h8001, 8'h99);
        @(negedge clk);
        check("abort_we_before", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_noack", {a_ack, b_ack}, 2'b00);
        end
        run_access(1'b0, 1'b0, 16'h8001, 8'h00);
        check("abort_old_data", a_rdata, 8'h11);

        // Random two-port traffic on a small address window to force overlap.
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; wt[p] = 0; rwe[p] = 1'b0; rad[p] = '0; rwd[p] = '0;
        end
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (mem_we) check("rnd_we_ram", mem_addr[15], 1'b1);
            for (int p = 0; p < 2; p++) begin
                ack_v = (p == 1) ? b_ack : a_ack;
                err_v = (p == 1) ? b_err : a_err;
                rd_v  = (p == 1) ? b_rdata : a_rdata;
                if (pend[p]) begin
                    wt[p]++;
                    if (ack_v) begin
                        perr = rwe[p] && !rad[p][15];
                        erd  = perr ? 8'h00 : ref_mem[rad[p]];
                        check("rnd_latency", wt[p] <= 6, 1'b1);
                        check("rnd_err", err_v, perr);
                        if (!rwe[p] || perr) check("rnd_rdata", rd_v, erd);
                        if (rwe[p] && rad[p][15]) ref_mem[rad[p]] = rwd[p];
                        pend[p] = 1'b0;
                        drive(p[0], 1'b0, $urandom_range(0, 1), 16'($urandom), 8'($urandom));
                    end else if (wt[p] > 6) begin
                        check("rnd_timeout", wt[p], 6);
                        pend[p] = 1'b0;
                        drive(p[0], 1'b0, 1'b0, 16'h0, 8'h0);
                    end
                end else begin
                    check("rnd_spurious_ack", ack_v, 1'b0);
                    if (cyc < 2900 && $urandom_range(0, 2) == 0) begin
                        pend[p] = 1'b1;
                        wt[p]   = 0;
                        rwe[p]  = 1'($urandom_range(0, 1));
                        rad[p]  = {1'($urandom_range(0, 3) != 0), 11'h0, 4'($urandom)};
                        rwd[p]  = 8'($urandom);
                        drive(p[0], 1'b1, rwe[p], rad[p], rwd[p]);
                    end
                end
            end
        end
        check("rnd_drained", {pend[0], pend[1]}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
